// File: rtl/demux1_4_lane_ctrl.sv
// demux1_4_lane_ctrl: round-robin byte striper driving a 1:4 lane demux.
// Partial stripes are padded; lane-mask changes land only on stripe boundaries.
module demux1_4_lane_ctrl #(
  parameter logic [7:0] PAD_BYTE     = 8'hBC,
  parameter logic [3:0] DEFAULT_MASK = 4'b1111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in0,
  input  logic        valid_in0,
  output logic        ready_in0,
  input  logic        cfg_load,
  input  logic [3:0]  lane_en,
  input  logic [3:0]  lane_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic [1:0]  out_sel,
  output logic        out_pad,
  output logic        stripe_done,
  output logic [3:0]  lane_mask,
  output logic [15:0] stripe_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;
  state_t     r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_mask;
  logic [3:0] r_pend;
  logic       w_acc;
  logic       w_pad_emit;
  logic       w_emit;
  logic       w_last;
  logic       w_apply;
  logic [1:0] w_next;
  function automatic logic [1:0] lowest(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction
  assign lane_mask = r_mask;
  // r_mask[r_ptr] is always set, so the pointer is the top lane when nothing lies above it
  always_comb begin
    ready_in0  = (r_state != PAD) & lane_ready[r_ptr];
    w_acc      = valid_in0 & ready_in0;
    w_pad_emit = (r_state == PAD) & lane_ready[r_ptr];
    w_emit     = w_acc | w_pad_emit;
    w_last     = (r_mask >> r_ptr) == 4'd1;
    w_next     = w_last ? lowest(r_mask) : lowest(r_mask & (4'b1110 << r_ptr));
    w_apply    = (r_state == IDLE) & ~w_acc & (r_pend != 4'd0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= lowest(DEFAULT_MASK);
      r_mask      <= DEFAULT_MASK;
      r_pend      <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sel     <= '0;
      out_pad     <= 1'b0;
      stripe_done <= 1'b0;
      stripe_cnt  <= '0;
    end else begin
      out_valid   <= w_emit;
      out_pad     <= w_pad_emit;
      stripe_done <= w_emit & w_last;
      if (w_emit) begin
        out_data <= w_acc ? in0 : PAD_BYTE;
        out_sel  <= r_ptr;
        r_ptr    <= w_next;
        r_state  <= w_last ? IDLE : (r_state == PAD) ? PAD : RUN;
        if (w_last) stripe_cnt <= stripe_cnt + 16'd1;
      end else if (r_state == RUN && !valid_in0) begin
        r_state <= PAD;
      end
      if (w_apply) begin
        r_mask <= r_pend;
        r_ptr  <= lowest(r_pend);
      end
      r_pend <= (cfg_load && lane_en != 4'd0) ? lane_en : w_apply ? 4'd0 : r_pend;
    end
  end
endmodule

// File: tb/tb_demux1_4_lane_ctrl.sv
// tb_demux1_4_lane_ctrl: directed stimulus with a stripe-position model checked every cycle.
module tb_demux1_4_lane_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in0 = '0;
  logic        valid_in0 = 1'b0;
  logic        ready_in0;
  logic        cfg_load = 1'b0;
  logic [3:0]  lane_en = '0;
  logic [3:0]  lane_ready = 4'hF;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_sel;
  logic        out_pad;
  logic        stripe_done;
  logic [3:0]  lane_mask;
  logic [15:0] stripe_cnt;
  int n_tests = 0;
  int n_fail = 0;
  demux1_4_lane_ctrl dut (
    .clk(clk), .reset(reset), .in0(in0), .valid_in0(valid_in0), .ready_in0(ready_in0),
    .cfg_load(cfg_load), .lane_en(lane_en), .lane_ready(lane_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sel(out_sel), .out_pad(out_pad),
    .stripe_done(stripe_done), .lane_mask(lane_mask), .stripe_cnt(stripe_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: the stripe is the ordered list of enabled lanes, m_k counts lanes already filled
  logic [3:0]  m_mask, m_pend;
  int          m_k;
  bit          m_padding;
  logic [15:0] m_cnt;
  bit          e_valid, e_pad, e_done;
  logic [7:0]  e_data;
  logic [1:0]  e_sel;
  logic [11:0] mlog[$];
  function automatic int cur_lane();
    int lanes[4];
    int n = 0;
    for (int i = 0; i < 4; i++) if (m_mask[i]) begin lanes[n] = i; n++; end
    return lanes[m_k];
  endfunction
  function automatic int n_lanes();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(m_mask[i]);
    return n;
  endfunction
  function automatic bit m_ready();
    return !m_padding && lane_ready[cur_lane()];
  endfunction
  function automatic logic [11:0] ent(input bit p, input bit d, input int s, input int dat);
    return {p, d, s[1:0], dat[7:0]};
  endfunction
  task automatic m_reset();
    m_mask = 4'hF; m_pend = 0; m_k = 0; m_padding = 0; m_cnt = 0;
    e_valid = 0; e_pad = 0; e_done = 0; e_data = 0; e_sel = 0;
  endtask
  task automatic m_step();
    int  cur = cur_lane();
    bit  acc = valid_in0 && !m_padding && lane_ready[cur];
    bit  pe  = m_padding && lane_ready[cur];
    e_valid = acc || pe; e_pad = pe; e_done = 0;
    if (acc || pe) begin
      e_data = acc ? in0 : 8'hBC;
      e_sel = 2'(cur);
      m_k++;
      if (m_k == n_lanes()) begin m_k = 0; m_padding = 0; e_done = 1; m_cnt++; end
      mlog.push_back(ent(e_pad, e_done, cur, int'(e_data)));
    end else if (m_k != 0 && !m_padding && !valid_in0) begin
      m_padding = 1;
    end else if (m_k == 0 && m_pend != 0) begin
      m_mask = m_pend; m_pend = 0;
    end
    if (cfg_load && lane_en != 0) m_pend = lane_en;
  endtask
  initial begin
    m_reset();
    forever begin
      @(negedge clk); #2;
      if (!reset) chk("ready_in0", int'(ready_in0), int'(m_ready()));
      @(posedge clk);
      if (reset) m_reset(); else m_step();
      #1;
      if (!reset) begin
        chk("out_valid", int'(out_valid), int'(e_valid));
        chk("out_data", int'(out_data), int'(e_data));
        chk("out_sel", int'(out_sel), int'(e_sel));
        chk("out_pad", int'(out_pad), int'(e_pad));
        chk("stripe_done", int'(stripe_done), int'(e_done));
        chk("stripe_cnt", int'(stripe_cnt), int'(m_cnt));
        chk("lane_mask", int'(lane_mask), int'(m_mask));
      end
    end
  end
  task automatic drv(input bit v, input logic [7:0] d, input logic [3:0] lr = 4'hF,
                     input bit cl = 1'b0, input logic [3:0] en = 4'h0);
    @(negedge clk);
    valid_in0 = v; in0 = d; lane_ready = lr; cfg_load = cl; lane_en = en;
  endtask
  task automatic log_is(input string nm, input int i, input logic [11:0] exp);
    chk(nm, (mlog.size() > i) ? int'(mlog[i]) : 32'hFFFF, int'(exp));
  endtask
  initial begin
    int c0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mask", int'(lane_mask), 4'hF);
    chk("rst_cnt", int'(stripe_cnt), 0);
    chk("rst_valid", int'(out_valid), 0);
    mlog.delete();
    for (int i = 1; i <= 8; i++) drv(1, 8'(i));
    repeat (2) drv(0, 0);
    for (int i = 0; i < 8; i++) log_is("t1_stream", i, ent(0, (i % 4) == 3, i % 4, i + 1));
    chk("t1_cnt", int'(stripe_cnt), 2);
    mlog.delete();
    drv(0, 0, 4'hF, 1, 4'b0101);
    drv(0, 0);
    drv(1, 8'hA0); drv(1, 8'hA1); drv(1, 8'hA2);
    repeat (3) drv(0, 0);
    log_is("t2_a0", 0, ent(0, 0, 0, 'hA0));
    log_is("t2_a1", 1, ent(0, 1, 2, 'hA1));
    log_is("t2_a2", 2, ent(0, 0, 0, 'hA2));
    log_is("t2_pad", 3, ent(1, 1, 2, 'hBC));
    chk("t2_mask", int'(lane_mask), 4'b0101);
    drv(0, 0, 4'hF, 1, 4'hF);
    repeat (2) drv(0, 0);
    mlog.delete();
    c0 = int'(stripe_cnt);
    drv(1, 8'h11); drv(1, 8'h22); drv(0, 0); drv(0, 0);
    #3 chk("t3_ready_pad", int'(ready_in0), 0);
    repeat (2) drv(0, 0);
    log_is("t3_11", 0, ent(0, 0, 0, 'h11));
    log_is("t3_22", 1, ent(0, 0, 1, 'h22));
    log_is("t3_pad2", 2, ent(1, 0, 2, 'hBC));
    log_is("t3_pad3", 3, ent(1, 1, 3, 'hBC));
    chk("t3_cnt", int'(stripe_cnt), c0 + 1);
    mlog.delete();
    drv(1, 8'h54);
    repeat (3) begin
      drv(1, 8'h55, 4'b1101);
      #3 chk("t4_ready_stall", int'(ready_in0), 0);
    end
    drv(1, 8'h55);
    #3 chk("t4_no_out", mlog.size(), 1);
    drv(1, 8'h56);
    #3 log_is("t4_55", 1, ent(0, 0, 1, 'h55));
    drv(1, 8'h57);
    repeat (2) drv(0, 0);
    log_is("t4_57", 3, ent(0, 1, 3, 'h57));
    mlog.delete();
    drv(1, 8'hB0);
    drv(1, 8'hB1, 4'hF, 1, 4'b0011);
    drv(1, 8'hB2, 4'hF, 1, 4'b0000);
    drv(1, 8'hB3);
    drv(0, 0);
    drv(0, 0);
    chk("t5_mask", int'(lane_mask), 4'b0011);
    drv(1, 8'hC0); drv(1, 8'hC1);
    repeat (2) drv(0, 0);
    for (int i = 0; i < 4; i++) log_is("t5_old", i, ent(0, i == 3, i, 'hB0 + i));
    log_is("t5_c0", 4, ent(0, 0, 0, 'hC0));
    log_is("t5_c1", 5, ent(0, 1, 1, 'hC1));
    drv(0, 0, 4'hF, 1, 4'hF);
    repeat (2) drv(0, 0);
    drv(1, 8'hD0);
    drv(0, 0, 4'h0);
    drv(0, 0, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_data", int'(out_data), 0);
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_sel", int'(out_sel), 0);
    chk("t6_pad", int'(out_pad), 0);
    chk("t6_done", int'(stripe_done), 0);
    chk("t6_cnt", int'(stripe_cnt), 0);
    chk("t6_mask", int'(lane_mask), 4'hF);
    mlog.delete();
    @(negedge clk);
    reset = 1'b0; lane_ready = 4'hF;
    repeat (4) drv(0, 0);
    chk("t6_no_pad", mlog.size(), 0);
    chk("t6_idle_valid", int'(out_valid), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
